// File: rtl/data_table_wr_arb.sv
// Write-port arbiter for the data-table RAM.
// Several requesters share one registered RAM write port; a clear sequence
// can take the port over to zero-fill the whole RAM, one word per cycle.
// Optional feature: define DATA_TABLE_WR_ARB_RR_EN for round-robin
// arbitration; otherwise fixed priority, lowest requester index first.
//
// state    | meaning
// ST_ARB   | normal operation, requesters compete for the write port
// ST_CLEAR | zero-fill in progress, one write per cycle, requests held off
module data_table_wr_arb #(
    parameter int A_WIDTH = 10,
    parameter int D_WIDTH = 59,
    parameter int REQ_CNT = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [REQ_CNT-1:0]         req_valid_i,
    input  logic [REQ_CNT*A_WIDTH-1:0] req_addr_i,
    input  logic [REQ_CNT*D_WIDTH-1:0] req_data_i,
    output logic [REQ_CNT-1:0]         req_ready_o,
    input  logic                       clear_ram_run_i,
    output logic                       clear_ram_done_o,
    output logic                       busy_o,
    output logic [A_WIDTH-1:0]         wr_addr_o,
    output logic [D_WIDTH-1:0]         wr_data_o,
    output logic                       wr_en_o
);

    localparam int PW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [D_WIDTH-1:0] wr_data_q, wr_data_d;
    logic               done;

    logic [REQ_CNT-1:0] grant;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      cand;
    logic               gnt_found;
    logic               accept;
    logic [PW-1:0]      search_base;

`ifdef DATA_TABLE_WR_ARB_RR_EN
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;

    // After granting requester k the search starts at k+1, wrapping to 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (gnt_idx == PW'(REQ_CNT - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign search_base = rr_ptr_q;
`else
    assign search_base = '0;
`endif

    // Pick the first valid requester starting at search_base; a clear
    // pulse or the CLEAR state blocks every grant.
    always_comb begin
        grant     = '0;
        gnt_idx   = '0;
        cand      = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < REQ_CNT; i++) begin
            cand = PW'((int'(search_base) + i) % REQ_CNT);
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (state_q == ST_ARB && !clear_ram_run_i && gnt_found) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign accept = |grant;

    // Next state, clear counter and next write-port contents.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        done      = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_ARB: begin
                if (clear_ram_run_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = req_addr_i[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
                    wr_data_d = req_data_i[int'(gnt_idx)*D_WIDTH +: D_WIDTH];
                end
            end
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = '0;
                // A new run pulse restarts from 0 and swallows the done pulse.
                if (clear_ram_run_i) begin
                    clr_cnt_d = '0;
                end else if (&clr_cnt_q) begin
                    done      = 1'b1;
                    state_d   = ST_ARB;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // State, counter and registered write port.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_ARB;
            clr_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign req_ready_o      = grant;
    assign clear_ram_done_o = done;
    assign busy_o           = (state_q == ST_CLEAR);
    assign wr_en_o          = wr_en_q;
    assign wr_addr_o        = wr_addr_q;
    assign wr_data_o        = wr_data_q;

endmodule

// File: tb/tb_data_table_wr_arb.sv
// Directed bench for data_table_wr_arb (A_WIDTH=4, two requesters).
module tb_data_table_wr_arb;

    localparam int AW = 4;
    localparam int DW = 59;
    localparam int RC = 2;

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic [RC-1:0]   req_valid_i = '0;
    logic [RC*AW-1:0] req_addr_i = '0;
    logic [RC*DW-1:0] req_data_i = '0;
    logic [RC-1:0]   req_ready_o;
    logic            clear_ram_run_i = 1'b0;
    logic            clear_ram_done_o;
    logic            busy_o;
    logic [AW-1:0]   wr_addr_o;
    logic [DW-1:0]   wr_data_o;
    logic            wr_en_o;

    data_table_wr_arb #(.A_WIDTH(AW), .D_WIDTH(DW), .REQ_CNT(RC)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .req_valid_i      (req_valid_i),
        .req_addr_i       (req_addr_i),
        .req_data_i       (req_data_i),
        .req_ready_o      (req_ready_o),
        .clear_ram_run_i  (clear_ram_run_i),
        .clear_ram_done_o (clear_ram_done_o),
        .busy_o           (busy_o),
        .wr_addr_o        (wr_addr_o),
        .wr_data_o        (wr_data_o),
        .wr_en_o          (wr_en_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Write/done monitor sampled on the falling edge.
    logic [AW-1:0] wr_log[$];
    int n_done = 0;
    always @(negedge clk_i) begin
        if (wr_en_o) wr_log.push_back(wr_addr_o);
        if (clear_ram_done_o) n_done++;
    end

    typedef struct {
        logic [1:0]    valid;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    ready;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [1:0] r,
                                input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        vec_t t;
        t.valid = v; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        t.ready = r; t.en = en; t.addr = addr; t.data = data;
        return t;
    endfunction

    localparam int NV = 9;
    vec_t vec[NV];

`ifdef DATA_TABLE_WR_ARB_RR_EN
    localparam logic [7:0] CONT_EXP = 8'b10_01_10_01;
`else
    localparam logic [7:0] CONT_EXP = 8'b01_01_01_01;
`endif

    initial begin
        logic [7:0]    cont_exp;
        logic [1:0]    g_prev;
        logic [1:0]    g_now;
        logic [DW-1:0] ones;
        int            base_w;
        int            base_d;
        int            exp_addr[$];

        ones = '1;
        cont_exp = CONT_EXP;
        // Expected outputs: ready is this row's grant, wr_* show the previous row's accept.
        vec[0] = mk(2'b01, 4'h5, 59'h1234, 4'h0, 59'h0,    2'b01, 1'b0, 4'h0, 59'h0);
        vec[1] = mk(2'b00, 4'h5, 59'h1234, 4'h0, 59'h0,    2'b00, 1'b1, 4'h5, 59'h1234);
        vec[2] = mk(2'b10, 4'h0, 59'h0,    4'h9, 59'hABCD, 2'b10, 1'b0, 4'h5, 59'h1234);
        vec[3] = mk(2'b00, 4'h0, 59'h0,    4'h9, 59'hABCD, 2'b00, 1'b1, 4'h9, 59'hABCD);
        vec[4] = mk(2'b00, 4'h0, 59'h0,    4'h0, 59'h0,    2'b00, 1'b0, 4'h9, 59'hABCD);
        vec[5] = mk(2'b01, 4'hF, ones,     4'h0, 59'h0,    2'b01, 1'b0, 4'h9, 59'hABCD);
        vec[6] = mk(2'b10, 4'hF, ones,     4'h0, 59'h0,    2'b10, 1'b1, 4'hF, ones);
        vec[7] = mk(2'b00, 4'h0, 59'h0,    4'h0, 59'h0,    2'b00, 1'b1, 4'h0, 59'h0);
        vec[8] = mk(2'b00, 4'h0, 59'h0,    4'h0, 59'h0,    2'b00, 1'b0, 4'h0, 59'h0);

        repeat (3) @(negedge clk_i);
        check("rst_wr_en", wr_en_o, 0);
        check("rst_wr_addr", wr_addr_o, 0);
        check("rst_wr_data", wr_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", clear_ram_done_o, 0);
        rst_n_i = 1'b1;

        // Table-driven single-requester vectors.
        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i); #1;
            req_valid_i = vec[i].valid;
            req_addr_i  = {vec[i].a1, vec[i].a0};
            req_data_i  = {vec[i].d1, vec[i].d0};
            @(negedge clk_i);
            check($sformatf("tbl%0d_ready", i), req_ready_o, vec[i].ready);
            check($sformatf("tbl%0d_wr_en", i), wr_en_o, vec[i].en);
            check($sformatf("tbl%0d_wr_addr", i), wr_addr_o, vec[i].addr);
            check($sformatf("tbl%0d_wr_data", i), wr_data_o, vec[i].data);
        end

        // Contention: both held for 4 cycles, then req 0 drops.
        g_prev = 2'b00;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            req_addr_i  = {4'h2, 4'h1};
            req_data_i  = {59'h22, 59'h11};
            req_valid_i = (k < 4) ? 2'b11 : ((k == 4) ? 2'b10 : 2'b00);
            g_now = (k < 4) ? cont_exp[2*k +: 2] : ((k == 4) ? 2'b10 : 2'b00);
            @(negedge clk_i);
            check($sformatf("cont%0d_ready", k), req_ready_o, g_now);
            if (k > 0) begin
                check($sformatf("cont%0d_wr_addr", k), wr_addr_o, g_prev[0] ? 64'h1 : 64'h2);
                check($sformatf("cont%0d_wr_data", k), wr_data_o, g_prev[0] ? 64'h11 : 64'h22);
            end
            g_prev = g_now;
        end

        // Full clear with a request held throughout.
        base_d = n_done;
        @(posedge clk_i); #1;
        req_valid_i = 2'b01;
        req_addr_i  = {4'h0, 4'h7};
        req_data_i  = {59'h0, 59'h77};
        clear_ram_run_i = 1'b1;
        @(negedge clk_i);
        check("run_beats_req", req_ready_o, 2'b00);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk_i); #1;
            clear_ram_run_i = 1'b0;
            @(negedge clk_i);
            check($sformatf("clr%0d_busy", c), busy_o, 1);
            check($sformatf("clr%0d_ready", c), req_ready_o, 2'b00);
            check($sformatf("clr%0d_done", c), clear_ram_done_o, (c == 15) ? 1 : 0);
            if (c > 0) begin
                check($sformatf("clr%0d_wr_en", c), wr_en_o, 1);
                check($sformatf("clr%0d_wr_addr", c), wr_addr_o, 64'(c - 1));
                check($sformatf("clr%0d_wr_data", c), wr_data_o, 0);
            end
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("post_clr_busy", busy_o, 0);
        check("post_clr_ready", req_ready_o, 2'b01);
        check("last_clr_wr_addr", wr_addr_o, 15);
        check("last_clr_wr_en", wr_en_o, 1);
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        @(negedge clk_i);
        check("held_req_wr_addr", wr_addr_o, 7);
        check("held_req_wr_data", wr_data_o, 59'h77);
        check("clr_done_count", n_done - base_d, 1);

        // Restart at address 7.
        @(posedge clk_i); #1;
        base_w = wr_log.size();
        base_d = n_done;
        clear_ram_run_i = 1'b1;
        @(posedge clk_i); #1;
        clear_ram_run_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #1 clear_ram_run_i = 1'b1;
        @(posedge clk_i); #1;
        clear_ram_run_i = 1'b0;
        repeat (18) @(posedge clk_i);
        @(negedge clk_i);
        for (int a = 0; a < 8; a++) exp_addr.push_back(a);
        for (int a = 0; a < 16; a++) exp_addr.push_back(a);
        check("rst_seq_len", wr_log.size() - base_w, exp_addr.size());
        for (int j = 0; j < exp_addr.size() && base_w + j < wr_log.size(); j++) begin
            check($sformatf("rst_seq_addr%0d", j), wr_log[base_w + j], exp_addr[j]);
        end
        check("restart_done_count", n_done - base_d, 1);

        // Reset in the middle of a clear.
        base_d = n_done;
        @(posedge clk_i); #1;
        clear_ram_run_i = 1'b1;
        @(posedge clk_i); #1;
        clear_ram_run_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_wr_addr", wr_addr_o, 2);
        rst_n_i = 1'b0;
        #1;
        check("midrst_wr_en", wr_en_o, 0);
        check("midrst_wr_addr", wr_addr_o, 0);
        check("midrst_wr_data", wr_data_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", clear_ram_done_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        base_w = wr_log.size();
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        check("post_rst_writes", wr_log.size() - base_w, 0);
        check("post_rst_done", n_done - base_d, 0);
        check("post_rst_busy", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
